// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module   : seg_disp_pkg
// Brief    : Shared types and constants for the seven-segment scan controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_disp_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    // All-anodes-off pattern for an n-digit display, LSB-aligned.
    function automatic logic [MAX_DIGITS-1:0] AN_OFF(input int n);
        logic [MAX_DIGITS-1:0] w_mask;
        w_mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                w_mask[i] = 1'b1;
            end
        end
        return w_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_decoder.sv
// ============================================================================
// Module   : seven_segment_decoder
// Brief    : Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seven_segment_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_scanner.sv
// ============================================================================
// Module   : seg_display_scanner
// Brief    : Time-multiplexed common-anode seven-segment scan controller with
//            frame-synchronous value capture and leading-zero suppression.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int c_CNT_W = $clog2(TICK_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_SHOW_LAST = c_CNT_W'(TICK_DIV - BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [MAX_DIGITS-1:0] c_AN_OFF_FULL = AN_OFF(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF      = c_AN_OFF_FULL[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE      = NUM_DIGITS'(1);

    localparam logic [1:0] c_ST_OFF  = OFF;
    localparam logic [1:0] c_ST_SHOW = SHOW;
    localparam logic [1:0] c_ST_GAP  = GAP;

    logic [NUM_DIGITS-1:0][3:0] r_pend_val;
    logic [NUM_DIGITS-1:0]      r_pend_dp;
    logic [NUM_DIGITS-1:0][3:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]      r_shadow_dp;

    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_wrap;

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_done;

    logic                  w_show_end;
    logic                  w_slot_end;
    logic                  w_wrap;
    logic                  w_frame_start;
    logic [NUM_DIGITS-1:0] w_zero_above;
    logic                  w_suppr;
    logic                  w_visible;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_dec;
    logic [NUM_DIGITS-1:0] w_an_sel;

    assign w_show_end    = (r_cnt == c_SHOW_LAST);
    assign w_slot_end    = (r_cnt == c_SLOT_LAST);
    assign w_wrap        = enable && (r_state == c_ST_GAP) && w_slot_end && (r_idx == c_IDX_LAST);
    assign w_frame_start = w_wrap || (enable && (r_state == c_ST_OFF));

    // Pending holds the latest load; the displayed copy only moves at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
        end else if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
        end else if (w_frame_start) begin
            r_shadow_val <= load ? value : r_pend_val;
            r_shadow_dp  <= load ? dp_in : r_pend_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_OFF;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
            if (!enable) begin
                r_state <= c_ST_OFF;
                r_idx   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_ST_OFF: begin
                        r_state <= c_ST_SHOW;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end
                    c_ST_SHOW: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_show_end) begin
                            r_state <= c_ST_GAP;
                        end
                    end
                    c_ST_GAP: begin
                        if (w_slot_end) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_SHOW;
                            r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_ST_OFF;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // w_zero_above[i] is set when nibbles i..top are all zero.
    always_comb begin
        logic v_acc;
        v_acc        = 1'b1;
        w_zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc           = v_acc && (r_shadow_val[i] == 4'h0);
            w_zero_above[i] = v_acc;
        end
    end

    assign w_suppr   = lz_blank && (r_idx != '0) && w_zero_above[r_idx];
    assign w_visible = digit_en[r_idx] && !w_suppr;
    assign w_nib     = r_shadow_val[r_idx];
    assign w_an_sel  = ~(c_AN_ONE << r_idx);

    seven_segment_decoder u_decoder (
        .nibble (w_nib),
        .seg    (w_seg_dec)
    );

    // A disabled-but-unsuppressed digit keeps its dp so slot timing stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= c_AN_OFF;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_wrap && enable;
            if (enable && (r_state == c_ST_SHOW)) begin
                r_an  <= w_visible ? w_an_sel : c_AN_OFF;
                r_seg <= w_seg_dec;
                r_dp  <= ~(r_shadow_dp[r_idx] && !w_suppr);
            end else begin
                r_an  <= c_AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
// ============================================================================
// Module   : tb_seg_display_scanner
// Brief    : Directed self-checking bench for seg_display_scanner (4 digits).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_scanner;

    localparam int NUM_DIGITS   = 4;
    localparam int TICK_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BLK = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_DIGITS   (NUM_DIGITS),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    // Leaves the bench in the first output cycle of a frame (frame_done high).
    task automatic wait_frame(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_frame_timeout: got no frame_done, required one within 100 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0;
        dp_in = '0; digit_en = '0; lz_blank = 1'b0;
        tick(3);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an: got %h required %h", an, 4'hF); end
        checks++; if (seg !== BLK) begin failures++; $display("FAIL reset_seg: got %h required %h", seg, BLK); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b required 0", frame_done); end
        rst_n = 1'b1;
        tick(3);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL off_an: got %h required %h", an, 4'hF); end
    endtask

    task automatic test_scan();
        logic [6:0] es [4];
        logic [3:0] one;
        es[0] = SF; es[1] = SA; es[2] = S2; es[3] = S1;
        one = 4'b0001;
        value = 16'h12AF; digit_en = 4'hF;
        pulse_load();
        tick(1);
        enable = 1'b1;
        tick(1);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL enable_t1_an: got %h required %h", an, 4'hF); end
        tick(1);
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL enable_t2_an: got %h required %h", an, 4'b1110); end
        wait_frame("scan");
        for (int c = 0; c < 32; c++) begin
            int d; int s;
            logic [3:0] ea; logic [6:0] eg; logic ef;
            d = c / 8; s = c % 8;
            ea = (s < 6) ? ~(one << d) : 4'hF;
            eg = (s < 6) ? es[d] : BLK;
            ef = (c == 0);
            checks++; if (an !== ea) begin failures++; $display("FAIL scan_an c=%0d: got %h required %h", c, an, ea); end
            checks++; if (seg !== eg) begin failures++; $display("FAIL scan_seg c=%0d: got %h required %h", c, seg, eg); end
            checks++; if (frame_done !== ef) begin failures++; $display("FAIL scan_fd c=%0d: got %b required %b", c, frame_done, ef); end
            tick(1);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL scan_period: got fd=%b required 1 at cycle 32", frame_done); end
    endtask

    task automatic test_lz();
        logic [3:0] one;
        one = 4'b0001;
        lz_blank = 1'b1;
        value = 16'h0030;
        pulse_load();
        wait_frame("lz30");
        for (int c = 0; c < 32; c++) begin
            int d; int s;
            logic [3:0] ea;
            d = c / 8; s = c % 8;
            ea = (s < 6 && d < 2) ? ~(one << d) : 4'hF;
            checks++; if (an !== ea) begin failures++; $display("FAIL lz30_an c=%0d: got %h required %h", c, an, ea); end
            if (s < 6 && d < 2) begin
                checks++;
                if (seg !== ((d == 1) ? S3 : S0)) begin
                    failures++; $display("FAIL lz30_seg c=%0d: got %h required %h", c, seg, (d == 1) ? S3 : S0);
                end
            end
            tick(1);
        end
        value = 16'h0000;
        pulse_load();
        wait_frame("lz00");
        for (int c = 0; c < 32; c++) begin
            int d; int s;
            logic [3:0] ea;
            d = c / 8; s = c % 8;
            ea = (s < 6 && d == 0) ? 4'b1110 : 4'hF;
            checks++; if (an !== ea) begin failures++; $display("FAIL lz00_an c=%0d: got %h required %h", c, an, ea); end
            if (s < 6 && d == 0) begin
                checks++; if (seg !== S0) begin failures++; $display("FAIL lz00_seg c=%0d: got %h required %h", c, seg, S0); end
            end
            tick(1);
        end
    endtask

    task automatic test_load_sync();
        lz_blank = 1'b0;
        tick(10);
        value = 16'hBEEF;
        pulse_load();
        tick(5);
        checks++; if (an !== 4'b1011 || seg !== S0) begin failures++; $display("FAIL old_d2: got an=%h seg=%h required an=b seg=%h", an, seg, S0); end
        tick(8);
        checks++; if (an !== 4'b0111 || seg !== S0) begin failures++; $display("FAIL old_d3: got an=%h seg=%h required an=7 seg=%h", an, seg, S0); end
        wait_frame("beef");
        checks++; if (an !== 4'b1110 || seg !== SF) begin failures++; $display("FAIL new_d0: got an=%h seg=%h required an=e seg=%h", an, seg, SF); end
        tick(8);
        checks++; if (an !== 4'b1101 || seg !== SE) begin failures++; $display("FAIL new_d1: got an=%h seg=%h required an=d seg=%h", an, seg, SE); end
        tick(8);
        checks++; if (an !== 4'b1011 || seg !== SE) begin failures++; $display("FAIL new_d2: got an=%h seg=%h required an=b seg=%h", an, seg, SE); end
        tick(8);
        checks++; if (an !== 4'b0111 || seg !== SB) begin failures++; $display("FAIL new_d3: got an=%h seg=%h required an=7 seg=%h", an, seg, SB); end
        // Load held on the cycle whose closing edge starts the next frame.
        tick(6);
        value = 16'h3456;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL coin_fd: got %b required 1", frame_done); end
        checks++; if (an !== 4'b1110 || seg !== S6) begin failures++; $display("FAIL coin_d0: got an=%h seg=%h required an=e seg=%h", an, seg, S6); end
        tick(8);
        checks++; if (seg !== S5) begin failures++; $display("FAIL coin_d1: got seg=%h required %h", seg, S5); end
    endtask

    task automatic test_dp_digit_en();
        logic [3:0] one;
        one = 4'b0001;
        dp_in = 4'b0100;
        digit_en = 4'b1011;
        pulse_load();
        wait_frame("dp");
        for (int c = 0; c < 32; c++) begin
            int d; int s;
            logic [3:0] ea; logic ed;
            d = c / 8; s = c % 8;
            ea = (s < 6 && d != 2) ? ~(one << d) : 4'hF;
            ed = !(s < 6 && d == 2);
            checks++; if (an !== ea) begin failures++; $display("FAIL dp_an c=%0d: got %h required %h", c, an, ea); end
            checks++; if (dp !== ed) begin failures++; $display("FAIL dp_dp c=%0d: got %b required %b", c, dp, ed); end
            tick(1);
        end
    endtask

    task automatic test_disable();
        int n;
        tick(18);
        checks++; if (dp !== 1'b0) begin failures++; $display("FAIL dis_pre_dp: got %b required 0", dp); end
        enable = 1'b0;
        tick(2);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL dis_an: got %h required %h", an, 4'hF); end
        checks++; if (seg !== BLK) begin failures++; $display("FAIL dis_seg: got %h required %h", seg, BLK); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL dis_dp: got %b required 1", dp); end
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (frame_done === 1'b1 || an !== 4'hF) n++;
            tick(1);
        end
        checks++; if (n != 0) begin failures++; $display("FAIL dis_quiet: got %0d active cycles required 0", n); end
        enable = 1'b1;
        tick(2);
        checks++; if (an !== 4'b1110 || seg !== S6) begin failures++; $display("FAIL reen_d0: got an=%h seg=%h required an=e seg=%h", an, seg, S6); end
    endtask

    task automatic test_async_reset();
        tick(5);
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL ar_pre_an: got %h required %h", an, 4'b1110); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL ar_an: got %h required %h", an, 4'hF); end
        checks++; if (seg !== BLK) begin failures++; $display("FAIL ar_seg: got %h required %h", seg, BLK); end
        checks++; if (dp !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL ar_dp_fd: got dp=%b fd=%b required 1 0", dp, frame_done); end
        enable = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL ar_off: got %h required %h", an, 4'hF); end
        value = 16'h9999;
        digit_en = 4'hF;
        enable = 1'b1;
        tick(2);
        checks++; if (an !== 4'b1110 || seg !== S0) begin failures++; $display("FAIL ar_pending: got an=%h seg=%h required an=e seg=%h", an, seg, S0); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_load_sync();
        test_dp_digit_en();
        test_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
